// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - M:SS.T BCD stopwatch core with start/stop/lap/clear FSM
//
// Purpose: counts 0.1 s ticks into four BCD digits under a start/stop/lap/clear
//          state machine and selects live or frozen lap digits for display.
// Ports:
//   clockin    - system clock
//   reset      - asynchronous active-low reset
//   tick       - one-cycle 0.1 s enable
//   btn_ss     - start/stop button level (asynchronous, debounced)
//   btn_lc     - lap/clear button level (asynchronous, debounced)
//   d0..d3     - displayed digits: tenths, seconds ones, seconds tens, minutes
//   running    - high in RUN or LAP
//   lap_active - high in LAP (display frozen)
//   ovf        - sticky terminal-count flag
module stopwatch_core #(
   parameter bit          SATURATE = 1'b1,
   parameter int unsigned MAX_MIN  = 9
) (
   input  logic       clockin,
   input  logic       reset,
   input  logic       tick,
   input  logic       btn_ss,
   input  logic       btn_lc,
   output logic [3:0] d0,
   output logic [3:0] d1,
   output logic [3:0] d2,
   output logic [3:0] d3,
   output logic       running,
   output logic       lap_active,
   output logic       ovf
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_LAP   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [3:0] MAX_D3 = MAX_MIN[3:0];

   state_t     state_q, state_d;
   logic [3:0] live0_q, live1_q, live2_q, live3_q;
   logic [3:0] live0_d, live1_d, live2_d, live3_d;
   logic [3:0] lap0_q, lap1_q, lap2_q, lap3_q;
   logic [3:0] lap0_d, lap1_d, lap2_d, lap3_d;
   logic       ovf_q, ovf_d;
   // bit 0 = first sync stage, bit 1 = second sync stage, bit 2 = previous value
   logic [2:0] ss_sync_q, ss_sync_d;
   logic [2:0] lc_sync_q, lc_sync_d;

   logic       ss_press, lc_press;
   logic       counting, terminal;
   logic [3:0] inc0, inc1, inc2, inc3;

   always_ff @(posedge clockin or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         live0_q   <= 4'd0;
         live1_q   <= 4'd0;
         live2_q   <= 4'd0;
         live3_q   <= 4'd0;
         lap0_q    <= 4'd0;
         lap1_q    <= 4'd0;
         lap2_q    <= 4'd0;
         lap3_q    <= 4'd0;
         ovf_q     <= 1'b0;
         ss_sync_q <= 3'd0;
         lc_sync_q <= 3'd0;
      end else begin
         state_q   <= state_d;
         live0_q   <= live0_d;
         live1_q   <= live1_d;
         live2_q   <= live2_d;
         live3_q   <= live3_d;
         lap0_q    <= lap0_d;
         lap1_q    <= lap1_d;
         lap2_q    <= lap2_d;
         lap3_q    <= lap3_d;
         ovf_q     <= ovf_d;
         ss_sync_q <= ss_sync_d;
         lc_sync_q <= lc_sync_d;
      end
   end

   // BCD increment with carry chain; the terminal count is handled separately,
   // so the minutes digit never needs to wrap here.
   always_comb begin
      inc0 = live0_q;
      inc1 = live1_q;
      inc2 = live2_q;
      inc3 = live3_q;
      if (live0_q == 4'd9) begin
         inc0 = 4'd0;
         if (live1_q == 4'd9) begin
            inc1 = 4'd0;
            if (live2_q == 4'd5) begin
               inc2 = 4'd0;
               inc3 = live3_q + 4'd1;
            end else begin
               inc2 = live2_q + 4'd1;
            end
         end else begin
            inc1 = live1_q + 4'd1;
         end
      end else begin
         inc0 = live0_q + 4'd1;
      end
   end

   always_comb begin
      ss_sync_d = {ss_sync_q[1:0], btn_ss};
      lc_sync_d = {lc_sync_q[1:0], btn_lc};
      ss_press  = ss_sync_q[1] & ~ss_sync_q[2];
      // start/stop wins a same-cycle collision
      lc_press  = lc_sync_q[1] & ~lc_sync_q[2] & ~ss_press;

      counting = ((state_q == ST_RUN) || (state_q == ST_LAP)) && tick;
      terminal = (live3_q == MAX_D3) && (live2_q == 4'd5) &&
                 (live1_q == 4'd9) && (live0_q == 4'd9);

      state_d = state_q;
      live0_d = live0_q;
      live1_d = live1_q;
      live2_d = live2_q;
      live3_d = live3_q;
      lap0_d  = lap0_q;
      lap1_d  = lap1_q;
      lap2_d  = lap2_q;
      lap3_d  = lap3_q;
      ovf_d   = ovf_q;

      // Counting uses the current state, so a tick on the edge that leaves
      // RUN/LAP is still counted and one on the edge that enters RUN is not.
      if (counting) begin
         if (terminal) begin
            ovf_d = 1'b1;
            if (!SATURATE) begin
               live0_d = 4'd0;
               live1_d = 4'd0;
               live2_d = 4'd0;
               live3_d = 4'd0;
            end
         end else begin
            live0_d = inc0;
            live1_d = inc1;
            live2_d = inc2;
            live3_d = inc3;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (ss_press) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (ss_press) begin
               state_d = ST_PAUSE;
            end else if (lc_press) begin
               state_d = ST_LAP;
               lap0_d  = live0_q;
               lap1_d  = live1_q;
               lap2_d  = live2_q;
               lap3_d  = live3_q;
            end
         end
         ST_LAP: begin
            if (ss_press)      state_d = ST_PAUSE;
            else if (lc_press) state_d = ST_RUN;
         end
         ST_PAUSE, ST_DONE: begin
            if (ss_press && (state_q == ST_PAUSE)) begin
               state_d = ST_RUN;
            end else if (lc_press) begin
               state_d = ST_IDLE;
               live0_d = 4'd0;
               live1_d = 4'd0;
               live2_d = 4'd0;
               live3_d = 4'd0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Saturation overrides any coincident button transition.
      if (SATURATE && counting && terminal) state_d = ST_DONE;
   end

   always_comb begin
      running    = (state_q == ST_RUN) || (state_q == ST_LAP);
      lap_active = (state_q == ST_LAP);
      ovf        = ovf_q;
      if (state_q == ST_LAP) begin
         d0 = lap0_q;
         d1 = lap1_q;
         d2 = lap2_q;
         d3 = lap3_q;
      end else begin
         d0 = live0_q;
         d1 = live1_q;
         d2 = live2_q;
         d3 = live3_q;
      end
   end

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - self-checking bench for stopwatch_core
module tb_stopwatch_core;

   typedef struct packed {
      logic [3:0] d3;
      logic [3:0] d2;
      logic [3:0] d1;
      logic [3:0] d0;
      logic       running;
      logic       lap;
      logic       ovf;
   } exp_t;

   logic clockin = 1'b0;
   logic reset   = 1'b1;
   logic tick    = 1'b0;
   logic btn_ss  = 1'b0;
   logic btn_lc  = 1'b0;

   logic [3:0] s_d0, s_d1, s_d2, s_d3, w_d0, w_d1, w_d2, w_d3;
   logic       s_run, s_lap, s_ovf, w_run, w_lap, w_ovf;
   exp_t       obs_s, obs_w;

   exp_t  sb_q[$];
   string nm_q[$];
   exp_t  e;
   string nm;
   int    errors = 0;
   int    checks = 0;

   always #5 clockin = ~clockin;

   stopwatch_core #(.SATURATE(1'b1), .MAX_MIN(1)) dut_s (
      .clockin(clockin), .reset(reset), .tick(tick), .btn_ss(btn_ss), .btn_lc(btn_lc),
      .d0(s_d0), .d1(s_d1), .d2(s_d2), .d3(s_d3),
      .running(s_run), .lap_active(s_lap), .ovf(s_ovf)
   );

   stopwatch_core #(.SATURATE(1'b0), .MAX_MIN(1)) dut_w (
      .clockin(clockin), .reset(reset), .tick(tick), .btn_ss(btn_ss), .btn_lc(btn_lc),
      .d0(w_d0), .d1(w_d1), .d2(w_d2), .d3(w_d3),
      .running(w_run), .lap_active(w_lap), .ovf(w_ovf)
   );

   assign obs_s = {s_d3, s_d2, s_d1, s_d0, s_run, s_lap, s_ovf};
   assign obs_w = {w_d3, w_d2, w_d1, w_d0, w_run, w_lap, w_ovf};

   // Expected display for a count of n tenths of a second.
   function automatic exp_t mk(input int n, input logic r, input logic l, input logic o);
      exp_t x;
      x.d3 = 4'(n / 600);
      x.d2 = 4'((n / 100) % 6);
      x.d1 = 4'((n / 10) % 10);
      x.d0 = 4'(n % 10);
      x.running = r;
      x.lap = l;
      x.ovf = o;
      return x;
   endfunction

   task automatic push(input exp_t x, input string n);
      sb_q.push_back(x);
      nm_q.push_back(n);
   endtask

   task automatic step();
      @(posedge clockin);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         step();
      end
   endtask

   // Buttons rise just after an edge; the state changes on the third edge.
   task automatic press(input logic ss, input logic lc, input logic with_tick);
      btn_ss = ss;
      btn_lc = lc;
      step();
      step();
      tick = with_tick;
      step();
      tick = 1'b0;
      btn_ss = 1'b0;
      btn_lc = 1'b0;
      repeat (3) step();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      push(mk(0, 0, 0, 0), "reset_held");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
      step();
      reset = 1'b1;
      step();
      push(mk(0, 0, 0, 0), "reset_released");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
   endtask

   task automatic test_count();
      do_reset();
      press(1'b1, 1'b0, 1'b0);
      ticks(25);
      push(mk(25, 1, 0, 0), "count_25");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
   endtask

   task automatic test_carry();
      do_reset();
      press(1'b1, 1'b0, 1'b0);
      ticks(599);
      push(mk(599, 1, 0, 0), "carry_0_59_9");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
      step();
      tick = 1'b1;
      step();
      push(mk(600, 1, 0, 0), "carry_1_00_0");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
      tick = 1'b0;
   endtask

   task automatic test_lap();
      do_reset();
      press(1'b1, 1'b0, 1'b0);
      ticks(34);
      press(1'b0, 1'b1, 1'b0);
      push(mk(34, 1, 1, 0), "lap_enter");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
      ticks(10);
      push(mk(34, 1, 1, 0), "lap_frozen");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
      press(1'b0, 1'b1, 1'b0);
      push(mk(44, 1, 0, 0), "lap_release");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
   endtask

   task automatic test_pause();
      do_reset();
      press(1'b1, 1'b0, 1'b0);
      ticks(10);
      press(1'b1, 1'b0, 1'b1);
      push(mk(11, 0, 0, 0), "pause_with_tick");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
      ticks(5);
      push(mk(11, 0, 0, 0), "pause_hold");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
      press(1'b1, 1'b0, 1'b1);
      push(mk(11, 1, 0, 0), "resume_tick_dropped");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      push(mk(0, 0, 0, 0), "pause_clear");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
   endtask

   task automatic test_terminal();
      do_reset();
      press(1'b1, 1'b0, 1'b0);
      ticks(1199);
      push(mk(1199, 1, 0, 0), "sat_before_terminal");
      push(mk(1199, 1, 0, 0), "wrap_before_terminal");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_w !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_w, e); end
      ticks(1);
      push(mk(1199, 0, 0, 1), "sat_done");
      push(mk(0, 1, 0, 1), "wrap_zero");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_w !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_w, e); end
      ticks(3);
      press(1'b1, 1'b0, 1'b0);
      push(mk(1199, 0, 0, 1), "sat_done_ignores_ss");
      push(mk(3, 0, 0, 1), "wrap_paused");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_w !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_w, e); end
      press(1'b0, 1'b1, 1'b0);
      push(mk(0, 0, 0, 0), "sat_clear");
      push(mk(0, 0, 0, 0), "wrap_clear");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_w !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_w, e); end
   endtask

   task automatic test_both_buttons();
      do_reset();
      press(1'b1, 1'b0, 1'b0);
      ticks(2);
      press(1'b0, 1'b1, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      ticks(3);
      press(1'b1, 1'b1, 1'b0);
      push(mk(5, 0, 0, 0), "both_pause");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      press(1'b1, 1'b0, 1'b0);
      ticks(7);
      push(mk(7, 1, 0, 0), "pre_reset_run");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
      step();
      // leave a start/stop press pending when reset hits
      btn_ss = 1'b1;
      step();
      step();
      #2 reset = 1'b0;
      #1;
      push(mk(0, 0, 0, 0), "async_reset");
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
      btn_ss = 1'b0;
      step();
      step();
      reset = 1'b1;
      repeat (4) step();
      push(mk(0, 0, 0, 0), "no_press_after_reset");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
      press(1'b1, 1'b0, 1'b0);
      ticks(1);
      push(mk(1, 1, 0, 0), "restart_after_reset");
      @(negedge clockin);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs_s, e); end
   endtask

   initial begin
      test_reset();
      test_count();
      test_carry();
      test_lap();
      test_pause();
      test_terminal();
      test_both_buttons();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
